// File: rtl/parking_controller_pkg.sv
// Shared constants for the four-slot car-park controller: slot count,
// display glyph codes and their seven-segment patterns {dp,g,f,e,d,c,b,a}.
package parking_controller_pkg;

    localparam int NUM_SLOTS  = 4;
    localparam int NUM_DIGITS = 5;

    // Codes 0..4 are the numerals themselves so counts map straight onto glyphs
    typedef enum logic [3:0] {
        G_0     = 4'd0,
        G_1     = 4'd1,
        G_2     = 4'd2,
        G_3     = 4'd3,
        G_4     = 4'd4,
        G_F     = 4'd5,
        G_U     = 4'd6,
        G_L     = 4'd7,
        G_DASH  = 4'd8,
        G_BLANK = 4'd9
    } glyph_e;

    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_F     = 8'h71;
    localparam logic [7:0] SEG_U     = 8'h3E;
    localparam logic [7:0] SEG_L     = 8'h38;
    localparam logic [7:0] SEG_DASH  = 8'h40;
    localparam logic [7:0] SEG_BLANK = 8'h00;

endpackage

// File: rtl/parking_controller_seven_seg_encoder.sv
// Maps a 4-bit glyph code to an active-high seven-segment pattern; dp is never lit.
module seven_seg_encoder
    import parking_controller_pkg::*;
(
    input  logic [3:0] code,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            G_0:     seg = SEG_0;
            G_1:     seg = SEG_1;
            G_2:     seg = SEG_2;
            G_3:     seg = SEG_3;
            G_4:     seg = SEG_4;
            G_F:     seg = SEG_F;
            G_U:     seg = SEG_U;
            G_L:     seg = SEG_L;
            G_DASH:  seg = SEG_DASH;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/parking_controller.sv
// Four-slot car-park controller: slot occupancy register with exit-over-entry
// priority, door pulse, capacity/best-place indicators and a 5-digit scanned display.
module parking_controller
    import parking_controller_pkg::*;
#(
    parameter int SCAN_DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       entry_sensor,
    input  logic       exit_sensor,
    input  logic [1:0] switch,
    output logic [3:0] parking_slots,
    output logic       door_open_light,
    output logic       full_light,
    output logic [2:0] capacity,
    output logic [2:0] best_place,
    output logic [7:0] sev_data,
    output logic [4:0] sev_sel
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [NUM_SLOTS-1:0] slots_q, slots_d;
    logic                 door_q, door_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [2:0]           digit_q, digit_d;

    logic       full_c;
    logic [2:0] free_cnt_c;
    logic [2:0] best_place_c;
    logic [1:0] best_idx_c;
    logic [3:0] glyph_c;

    // Popcount of free slots and lowest-free priority encoder (scan high to low so lowest wins)
    always_comb begin
        free_cnt_c   = 3'd0;
        best_place_c = 3'd0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slots_q[i]) begin
                free_cnt_c   = free_cnt_c + 3'd1;
                best_place_c = 3'(i + 1);
            end
        end
        full_c     = (slots_q == '1);
        best_idx_c = 2'(best_place_c - 3'd1);
    end

    always_comb begin
        slots_d = slots_q;
        door_d  = 1'b0;
        if (exit_sensor) begin
            if (slots_q[switch]) begin
                slots_d[switch] = 1'b0;
                door_d          = 1'b1;
            end
        end else if (entry_sensor && !full_c) begin
            slots_d[best_idx_c] = 1'b1;
            door_d              = 1'b1;
        end
    end

    always_comb begin
        div_d   = div_q + DIV_W'(1);
        digit_d = digit_q;
        if (div_q == DIV_LAST) begin
            div_d   = '0;
            digit_d = (digit_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : digit_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slots_q <= '0;
            door_q  <= 1'b0;
            div_q   <= '0;
            digit_q <= 3'd0;
        end else begin
            slots_q <= slots_d;
            door_q  <= door_d;
            div_q   <= div_d;
            digit_q <= digit_d;
        end
    end

    always_comb begin
        glyph_c = G_BLANK;
        case (digit_q)
            3'd0:    glyph_c = {1'b0, free_cnt_c};
            3'd1:    glyph_c = full_c ? G_DASH : {1'b0, best_place_c};
            3'd2:    glyph_c = full_c ? G_F : G_BLANK;
            3'd3:    glyph_c = full_c ? G_U : G_BLANK;
            3'd4:    glyph_c = full_c ? G_L : G_BLANK;
            default: glyph_c = G_BLANK;
        endcase
    end

    seven_seg_encoder u_seg (
        .code (glyph_c),
        .seg  (sev_data)
    );

    assign parking_slots   = slots_q;
    assign door_open_light = door_q;
    assign full_light      = full_c;
    assign capacity        = free_cnt_c;
    assign best_place      = best_place_c;
    assign sev_sel         = 5'b00001 << digit_q;

endmodule

// File: tb/tb_parking_controller.sv
// Directed bench for parking_controller: occupancy, priority, full handling and display scan.
module tb_parking_controller;

    logic       clk;
    logic       rst;
    logic       entry_sensor;
    logic       exit_sensor;
    logic [1:0] switch;
    logic [3:0] parking_slots;
    logic       door_open_light;
    logic       full_light;
    logic [2:0] capacity;
    logic [2:0] best_place;
    logic [7:0] sev_data;
    logic [4:0] sev_sel;

    int checks = 0;
    int errors = 0;

    parking_controller #(.SCAN_DIV(1)) dut (
        .clk             (clk),
        .rst             (rst),
        .entry_sensor    (entry_sensor),
        .exit_sensor     (exit_sensor),
        .switch          (switch),
        .parking_slots   (parking_slots),
        .door_open_light (door_open_light),
        .full_light      (full_light),
        .capacity        (capacity),
        .best_place      (best_place),
        .sev_data        (sev_data),
        .sev_sel         (sev_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Apply inputs at the falling edge, let one rising edge act, sample at next falling edge
    task automatic step(input logic en, input logic ex, input logic [1:0] sw);
        entry_sensor = en;
        exit_sensor  = ex;
        switch       = sw;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Idle until the given digit is selected (bounded), then check its segments
    task automatic check_digit(input string tag, input logic [4:0] sel, input logic [7:0] exp);
        int n;
        n = 0;
        while (sev_sel !== sel && n < 8) begin
            step(1'b0, 1'b0, 2'd0);
            n++;
        end
        check({tag, "_sel"}, sev_sel, sel);
        check(tag, sev_data, exp);
    endtask

    task automatic check_slots(input string tag, input logic [3:0] slots, input logic door,
                               input logic [2:0] cap, input logic [2:0] bp, input logic full);
        check({tag, "_slots"}, parking_slots, slots);
        check({tag, "_door"}, door_open_light, door);
        check({tag, "_cap"}, capacity, cap);
        check({tag, "_best"}, best_place, bp);
        check({tag, "_full"}, full_light, full);
    endtask

    initial begin
        logic [4:0] scan_exp [5];
        scan_exp[0] = 5'b00010;
        scan_exp[1] = 5'b00100;
        scan_exp[2] = 5'b01000;
        scan_exp[3] = 5'b10000;
        scan_exp[4] = 5'b00001;

        rst = 1'b1;
        entry_sensor = 1'b1;
        exit_sensor = 1'b0;
        switch = 2'd0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_slots("reset", 4'b0000, 1'b0, 3'd4, 3'd1, 1'b0);
        check("reset_sel", sev_sel, 5'b00001);
        check("reset_data", sev_data, 8'h66);
        rst = 1'b0;

        // Single entry, then door drops
        step(1'b1, 1'b0, 2'd0);
        check_slots("entry1", 4'b0001, 1'b1, 3'd3, 3'd2, 1'b0);
        step(1'b0, 1'b0, 2'd0);
        check_slots("idle1", 4'b0001, 1'b0, 3'd3, 3'd2, 1'b0);

        // Simultaneous entry and exit: exit wins
        step(1'b1, 1'b1, 2'd0);
        check_slots("both", 4'b0000, 1'b1, 3'd4, 3'd1, 1'b0);

        // Fill all four, then a rejected fifth
        step(1'b1, 1'b0, 2'd3);
        check("fill1_slots", parking_slots, 4'b0001);
        step(1'b1, 1'b0, 2'd3);
        check("fill2_slots", parking_slots, 4'b0011);
        step(1'b1, 1'b0, 2'd3);
        check("fill3_slots", parking_slots, 4'b0111);
        step(1'b1, 1'b0, 2'd3);
        check_slots("fill4", 4'b1111, 1'b1, 3'd0, 3'd0, 1'b1);
        step(1'b1, 1'b0, 2'd3);
        check_slots("reject", 4'b1111, 1'b0, 3'd0, 3'd0, 1'b1);

        check_digit("full_d2", 5'b00100, 8'h71);
        check_digit("full_d3", 5'b01000, 8'h3E);
        check_digit("full_d4", 5'b10000, 8'h38);
        check_digit("full_d0", 5'b00001, 8'h3F);
        check_digit("full_d1", 5'b00010, 8'h40);

        // Release slot 2, then exit on the now-empty slot is refused
        step(1'b0, 1'b1, 2'd2);
        check_slots("exit2", 4'b1011, 1'b1, 3'd1, 3'd3, 1'b0);
        step(1'b0, 1'b1, 2'd2);
        check_slots("exit2_again", 4'b1011, 1'b0, 3'd1, 3'd3, 1'b0);

        check_digit("part_d2", 5'b00100, 8'h00);
        check_digit("part_d0", 5'b00001, 8'h06);
        check_digit("part_d1", 5'b00010, 8'h4F);

        // Entry refills the freed slot 2
        step(1'b1, 1'b0, 2'd0);
        check_slots("refill", 4'b1111, 1'b1, 3'd0, 3'd0, 1'b1);

        // Scan sequence from reset, then reset mid-scan
        rst = 1'b1;
        step(1'b0, 1'b0, 2'd0);
        check("scan_rst_sel", sev_sel, 5'b00001);
        check("scan_rst_slots", parking_slots, 4'b0000);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 2'd0);
            check($sformatf("scan%0d", i + 1), sev_sel, scan_exp[i]);
        end
        step(1'b0, 1'b0, 2'd0);
        step(1'b0, 1'b0, 2'd0);
        check("midscan_sel", sev_sel, 5'b00100);
        rst = 1'b1;
        step(1'b0, 1'b0, 2'd0);
        check("midscan_rst_sel", sev_sel, 5'b00001);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
